// File: rtl/pc_fetch.sv
// Purpose: program-counter fetch stage with RUN/HALT control and a retired-advance counter.
// Latency: pc, halted and retired update on the rising clock edge; pc4 and the decode fields are combinational.
// Backpressure: PCwrt low parks the fetch in HALT with pc held until a single-cycle resume.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCwrt,
  input  logic        jump,
  input  logic        branch,
  input  logic        resume,
  input  logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sa,
  output logic [15:0] imm,
  output logic        halted,
  output logic [31:0] retired
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] br_off;
  logic [31:0] next_pc;

  // Instruction field decode is pure wiring so fields follow instr with no added latency.
  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign sa     = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  assign pc      = pc_q;
  assign pc4     = pc_q + 32'd4;
  assign halted  = (state_q == ST_HALT);
  assign retired = retired_q;

  // Word-scaled, sign-extended branch displacement; low two bits are always zero.
  assign br_off = {{14{imm[15]}}, imm, 2'b00};

  // Next-PC select: jump wins over branch, which wins over the sequential step.
  always_comb begin
    next_pc = pc4;
    if (jump) begin
      next_pc = {pc4[31:28], instr[25:0], 2'b00};
    end else if (branch) begin
      next_pc = pc4 + br_off;
    end
  end

  // RUN/HALT control: only a RUN advance counts as retired; the resume step skips the halt word.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    case (state_q)
      ST_RUN: begin
        if (PCwrt) begin
          pc_d      = next_pc;
          retired_d = retired_q + 32'd1;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (resume) begin
          pc_d    = pc4;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State registers; reset forces the start PC immediately, independent of the clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: three instances (reset PC 0, 0xFFFF_FFFC, 0x4000_0000) driven by directed vectors.
// The driver pushes hand-computed expectations; a negedge monitor pops and compares them.
// All DUT outputs are sampled on the falling edge, away from the active rising edge.
module tb_pc_fetch;

  logic        clk;
  logic        rst;
  logic [2:0]  pcwrt_i, jump_i, branch_i, resume_i;
  logic [31:0] instr_i   [3];
  logic [31:0] pc_o      [3];
  logic [31:0] pc4_o     [3];
  logic [5:0]  op_o      [3];
  logic [5:0]  funct_o   [3];
  logic [4:0]  rs_o      [3];
  logic [4:0]  rt_o      [3];
  logic [4:0]  rd_o      [3];
  logic [4:0]  sa_o      [3];
  logic [15:0] imm_o     [3];
  logic [2:0]  halted_o;
  logic [31:0] retired_o [3];

  int total;
  int bad;

  typedef struct {
    int          d;
    logic [31:0] pc;
    logic        h;
    logic [31:0] ret;
    logic [31:0] ins;
    string       nm;
  } item_t;

  item_t sb[$];

  pc_fetch #(.RESET_PC(32'h0000_0000)) u_dut0 (
    .clk(clk), .rst(rst), .PCwrt(pcwrt_i[0]), .jump(jump_i[0]), .branch(branch_i[0]),
    .resume(resume_i[0]), .instr(instr_i[0]), .pc(pc_o[0]), .pc4(pc4_o[0]), .op(op_o[0]),
    .funct(funct_o[0]), .rs(rs_o[0]), .rt(rt_o[0]), .rd(rd_o[0]), .sa(sa_o[0]), .imm(imm_o[0]),
    .halted(halted_o[0]), .retired(retired_o[0])
  );

  pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (
    .clk(clk), .rst(rst), .PCwrt(pcwrt_i[1]), .jump(jump_i[1]), .branch(branch_i[1]),
    .resume(resume_i[1]), .instr(instr_i[1]), .pc(pc_o[1]), .pc4(pc4_o[1]), .op(op_o[1]),
    .funct(funct_o[1]), .rs(rs_o[1]), .rt(rt_o[1]), .rd(rd_o[1]), .sa(sa_o[1]), .imm(imm_o[1]),
    .halted(halted_o[1]), .retired(retired_o[1])
  );

  pc_fetch #(.RESET_PC(32'h4000_0000)) u_dut2 (
    .clk(clk), .rst(rst), .PCwrt(pcwrt_i[2]), .jump(jump_i[2]), .branch(branch_i[2]),
    .resume(resume_i[2]), .instr(instr_i[2]), .pc(pc_o[2]), .pc4(pc4_o[2]), .op(op_o[2]),
    .funct(funct_o[2]), .rs(rs_o[2]), .rt(rt_o[2]), .rd(rd_o[2]), .sa(sa_o[2]), .imm(imm_o[2]),
    .halted(halted_o[2]), .retired(retired_o[2])
  );

  // Free-running clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: bumps total, and bad plus a FAIL line on mismatch.
  task automatic cmp(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s actual=%h required=%h", nm, what, act, exp);
    end
  endtask

  // Drive one instance's inputs and queue the state it must show in this cycle.
  task automatic set_d(input int d, input logic pw, input logic j, input logic b, input logic r,
                       input logic [31:0] ins, input logic [31:0] epc, input logic eh,
                       input logic [31:0] eret, input string nm);
    item_t it;
    pcwrt_i[d]  = pw;
    jump_i[d]   = j;
    branch_i[d] = b;
    resume_i[d] = r;
    instr_i[d]  = ins;
    it.d   = d;
    it.pc  = epc;
    it.h   = eh;
    it.ret = eret;
    it.ins = ins;
    it.nm  = nm;
    sb.push_back(it);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every falling edge, check everything the driver queued since the last one.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        it = sb.pop_front();
        cmp(it.nm, "pc", pc_o[it.d], it.pc);
        cmp(it.nm, "halted", {31'd0, halted_o[it.d]}, {31'd0, it.h});
        cmp(it.nm, "retired", retired_o[it.d], it.ret);
        cmp(it.nm, "pc4", pc4_o[it.d], it.pc + 32'd4);
        cmp(it.nm, "fields", {op_o[it.d], rs_o[it.d], rt_o[it.d], rd_o[it.d], sa_o[it.d], funct_o[it.d]}, it.ins);
        cmp(it.nm, "imm", {16'd0, imm_o[it.d]}, {16'd0, it.ins[15:0]});
      end
    end
  end

  // Watchdog: the run is a fixed-length directed sequence, so this only fires on a bench hang.
  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    total = 0;
    bad   = 0;
    rst      = 1'b1;
    pcwrt_i  = 3'b000;
    jump_i   = 3'b000;
    branch_i = 3'b000;
    resume_i = 3'b000;
    for (int k = 0; k < 3; k++) instr_i[k] = 32'd0;
    tick();

    // Held in reset across an edge: every instance sits at its reset PC.
    set_d(0, 1, 0, 0, 0, 32'h012A_4020, 32'h0000_0000, 0, 0, "rst0");
    set_d(1, 1, 0, 0, 0, 32'h0000_0000, 32'hFFFF_FFFC, 0, 0, "rst1");
    set_d(2, 1, 1, 1, 0, 32'h0800_0100, 32'h4000_0000, 0, 0, "rst2");
    tick();

    // First edge after release performs a normal update.
    rst = 1'b0;
    set_d(0, 1, 0, 0, 0, 32'h012A_4020, 32'h0000_0000, 0, 0, "seq0");
    set_d(1, 1, 0, 0, 0, 32'h0000_0000, 32'hFFFF_FFFC, 0, 0, "wrap_pre");
    set_d(2, 1, 1, 1, 0, 32'h0800_0100, 32'h4000_0000, 0, 0, "jb_pre");
    tick();

    // Wrap to 0, jump beats branch (branch would give 0x4000_0404); resume ignored in RUN.
    set_d(0, 1, 0, 0, 1, 32'h8C43_0010, 32'h0000_0004, 0, 1, "seq1");
    set_d(1, 0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0, 1, "wrap");
    set_d(2, 0, 0, 0, 0, 32'h0800_0100, 32'h4000_0400, 0, 1, "jump_win");
    tick();
    set_d(0, 1, 0, 0, 0, 32'hAFBF_0004, 32'h0000_0008, 0, 2, "seq2");
    tick();
    set_d(0, 1, 0, 0, 0, 32'h0003_1080, 32'h0000_000C, 0, 3, "seq3");
    tick();

    // Branches: 0x10 + 4 - 16 = 0x04; 0x04 + 4 + 8 = 0x10; 0x10 + 4 + 12 = 0x20; 0x20 + 4 - 16 = 0x14.
    set_d(0, 1, 0, 1, 0, 32'h1000_FFFC, 32'h0000_0010, 0, 4, "br_back");
    tick();
    set_d(0, 1, 0, 1, 0, 32'h1000_0002, 32'h0000_0004, 0, 5, "br_fwd2");
    tick();
    set_d(0, 1, 0, 1, 0, 32'h1000_0003, 32'h0000_0010, 0, 6, "br_fwd3");
    tick();
    set_d(0, 1, 0, 1, 0, 32'h1000_FFFC, 32'h0000_0020, 0, 7, "br_to14");
    tick();

    // Halt at 0x14 even with jump and resume high; halted shows one cycle later.
    set_d(0, 0, 1, 0, 1, 32'h0000_000D, 32'h0000_0014, 0, 8, "halt_in");
    tick();
    set_d(0, 1, 1, 1, 0, 32'h0000_000D, 32'h0000_0014, 1, 8, "halt_c1");
    tick();
    set_d(0, 1, 0, 0, 0, 32'h0000_000D, 32'h0000_0014, 1, 8, "halt_c2");
    tick();
    set_d(0, 0, 0, 1, 0, 32'h0000_000D, 32'h0000_0014, 1, 8, "halt_c3");
    tick();
    set_d(0, 1, 1, 0, 0, 32'h0000_000D, 32'h0000_0014, 1, 8, "halt_c4");
    tick();
    set_d(0, 0, 1, 1, 1, 32'h0000_000D, 32'h0000_0014, 1, 8, "halt_c5");
    tick();

    // Resume skipped the halt word without counting it, then a sequential step and a jump to 0x100.
    set_d(0, 1, 0, 0, 0, 32'h012A_4020, 32'h0000_0018, 0, 8, "resumed");
    tick();
    set_d(0, 1, 1, 0, 0, 32'h0800_0040, 32'h0000_001C, 0, 9, "jmp_pre");
    tick();
    set_d(0, 0, 0, 0, 0, 32'h0000_000D, 32'h0000_0100, 0, 10, "halt100");
    tick();
    set_d(0, 1, 1, 1, 1, 32'h0000_000D, 32'h0000_0100, 1, 10, "halted100");
    tick();

    // Reset asserted mid-cycle in HALT; checked at the falling edge with no rising edge in between.
    #2;
    rst = 1'b1;
    set_d(0, 1, 1, 1, 1, 32'h0800_0040, 32'h0000_0000, 0, 0, "arst");
    tick();
    set_d(0, 1, 1, 1, 0, 32'h0800_0040, 32'h0000_0000, 0, 0, "rst_hold");
    tick();
    rst = 1'b0;
    set_d(0, 1, 0, 0, 0, 32'h012A_4020, 32'h0000_0000, 0, 0, "post_rst");
    tick();
    set_d(0, 1, 0, 0, 0, 32'h8C43_0010, 32'h0000_0004, 0, 1, "post_seq");
    @(negedge clk);
    #1;

    cmp("drain", "queue", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
